// File: rtl/cs_wait_state_gen_pkg.sv
// Shared definitions for the chip-select wait-state generator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cs_wait_state_gen_pkg;

  // Bus-cycle state: IDLE passes selects through, WAIT holds them and stretches RDY.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } cs_state_t;

  // Default wait-state map for 8 selects x 3 bits: CS0 (ROM) gets 2 PHI2 cycles.
  localparam logic [23:0] CS_WAIT_CFG_DEFAULT = 24'h000_002;

  // Number of selects and count width the default map is laid out for.
  localparam int CS_NUM_DEFAULT    = 8;
  localparam int CS_WAIT_W_DEFAULT = 3;

endpackage

// File: rtl/cs_wait_state_gen_phi2_sync.sv
// Synchronises the asynchronous PHI2 pin into clk and flags its rising edge.
// Latency: rise pulse is high SYNC_STAGES clks after the pin edge is first sampled.
// Backpressure: none; free-running, one-clk rise pulse per PHI2 period.
module cs_wait_state_gen_phi2_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic phi2_in,
  output logic phi2_rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // Shift PHI2 through the synchroniser chain and keep one history bit for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], phi2_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // The rise is decoded from flops only, so it is glitch-free for the FSM.
  assign phi2_rise = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/cs_wait_state_gen.sv
// Registers 6502 chip selects for the whole bus cycle and stretches RDY per device.
// Latency: cs_n_out follows cs_n_in by 1 clk in IDLE; RDY drops 1 clk after the PHI2 rise.
// Backpressure: rdy_out=0 stalls the CPU for cfg[i] PHI2 periods; inputs are ignored in WAIT.
module cs_wait_state_gen
  import cs_wait_state_gen_pkg::*;
#(
  parameter int                        NUM_CS      = CS_NUM_DEFAULT,
  parameter int                        WAIT_W      = CS_WAIT_W_DEFAULT,
  parameter logic [NUM_CS*WAIT_W-1:0]  WAIT_CFG    = CS_WAIT_CFG_DEFAULT,
  parameter int                        SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              phi2_in,
  input  logic [NUM_CS-1:0] cs_n_in,
  output logic [NUM_CS-1:0] cs_n_out,
  output logic              rdy_out,
  output logic              wait_active,
  output logic              multi_sel_err
);

  localparam int ZC_W = $clog2(NUM_CS + 1);

  logic              phi2_rise;

  cs_state_t         state_q, state_nxt;
  logic [WAIT_W-1:0] cnt_q, cnt_nxt;
  logic [NUM_CS-1:0] cs_lat_q, cs_lat_nxt;
  logic [NUM_CS-1:0] cs_out_nxt;
  logic              rdy_nxt;
  logic              wait_nxt;
  logic              err_nxt;

  logic [ZC_W-1:0]   zero_cnt;
  logic [WAIT_W-1:0] sel_cfg;

  cs_wait_state_gen_phi2_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_phi2_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .phi2_in   (phi2_in),
    .phi2_rise (phi2_rise)
  );

  // Count asserted selects and pick the wait count of the (last) asserted one;
  // the count is only used when exactly one select is low.
  always_comb begin
    zero_cnt = '0;
    sel_cfg  = '0;
    for (int i = 0; i < NUM_CS; i++) begin
      if (!cs_n_in[i]) begin
        zero_cnt = zero_cnt + ZC_W'(1);
        sel_cfg  = WAIT_CFG[i*WAIT_W +: WAIT_W];
      end
    end
  end

  // Next-state and next-output logic; every output is registered from these values.
  always_comb begin
    state_nxt  = state_q;
    cnt_nxt    = cnt_q;
    cs_lat_nxt = cs_lat_q;
    cs_out_nxt = cs_n_out;
    rdy_nxt    = 1'b1;
    wait_nxt   = 1'b0;
    err_nxt    = 1'b0;

    if (!ena) begin
      // Disable wins over any PHI2 edge seen in the same clk.
      state_nxt  = ST_IDLE;
      cnt_nxt    = '0;
      cs_out_nxt = '1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          cs_out_nxt = cs_n_in;
          if (phi2_rise) begin
            if (zero_cnt > ZC_W'(1)) begin
              err_nxt = 1'b1;
            end else if (zero_cnt == ZC_W'(1) && sel_cfg != '0) begin
              state_nxt  = ST_WAIT;
              cnt_nxt    = sel_cfg;
              cs_lat_nxt = cs_n_in;
              rdy_nxt    = 1'b0;
              wait_nxt   = 1'b1;
            end
          end
        end

        ST_WAIT: begin
          // Select is frozen for the stretched cycle even if the decoder moves on.
          cs_out_nxt = cs_lat_q;
          rdy_nxt    = 1'b0;
          wait_nxt   = 1'b1;
          if (phi2_rise) begin
            if (cnt_q == WAIT_W'(1)) begin
              state_nxt = ST_IDLE;
              cnt_nxt   = '0;
              rdy_nxt   = 1'b1;
              wait_nxt  = 1'b0;
            end else begin
              cnt_nxt = cnt_q - WAIT_W'(1);
            end
          end
        end

        default: begin
          state_nxt  = ST_IDLE;
          cnt_nxt    = '0;
          cs_out_nxt = '1;
        end
      endcase
    end
  end

  // State, counter, latched select and all outputs; reset acts at once, even mid-WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      cs_lat_q      <= '1;
      cs_n_out      <= '1;
      rdy_out       <= 1'b1;
      wait_active   <= 1'b0;
      multi_sel_err <= 1'b0;
    end else begin
      state_q       <= state_nxt;
      cnt_q         <= cnt_nxt;
      cs_lat_q      <= cs_lat_nxt;
      cs_n_out      <= cs_out_nxt;
      rdy_out       <= rdy_nxt;
      wait_active   <= wait_nxt;
      multi_sel_err <= err_nxt;
    end
  end

endmodule

// File: tb/tb_cs_wait_state_gen.sv
// Directed bench for cs_wait_state_gen: two instances (default map, and CS7=7).
// PHI2 period is 8 clks, so an N-wait cycle keeps RDY low for exactly 8*N clks.
// Outputs are sampled on the falling clock edge.
module tb_cs_wait_state_gen;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       phi2;
  logic [7:0] cs1_in, cs2_in;
  logic [7:0] cs1_out, cs2_out;
  logic       rdy1, rdy2;
  logic       wait1, wait2;
  logic       err1, err2;

  int n_cmp = 0;
  int n_bad = 0;
  logic use2 = 1'b0;
  logic mon_rdy;

  assign mon_rdy = use2 ? rdy2 : rdy1;

  cs_wait_state_gen dut1 (
    .clk           (clk),
    .rst_n         (rst_n),
    .ena           (ena),
    .phi2_in       (phi2),
    .cs_n_in       (cs1_in),
    .cs_n_out      (cs1_out),
    .rdy_out       (rdy1),
    .wait_active   (wait1),
    .multi_sel_err (err1)
  );

  cs_wait_state_gen #(
    .WAIT_CFG (24'hE00_002)
  ) dut2 (
    .clk           (clk),
    .rst_n         (rst_n),
    .ena           (ena),
    .phi2_in       (phi2),
    .cs_n_in       (cs2_in),
    .cs_n_out      (cs2_out),
    .rdy_out       (rdy2),
    .wait_active   (wait2),
    .multi_sel_err (err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PHI2 toggles every 4 clks, offset from the clock edges.
  initial begin
    phi2 = 1'b0;
    #2;
    forever #40 phi2 = ~phi2;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_low(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!mon_rdy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Returns at the first sample where RDY is high again.
  task automatic count_low(input int start, output int n);
    n = start;
    while (n < 200) begin
      @(negedge clk);
      if (mon_rdy) break;
      n++;
    end
  endtask

  task automatic count_high(input int start, output int n);
    n = start;
    while (n < 200) begin
      @(negedge clk);
      if (!mon_rdy) break;
      n++;
    end
  endtask

  initial begin
    bit ok;
    int n;
    int errs;
    int lows;

    rst_n  = 1'b0;
    ena    = 1'b1;
    cs1_in = 8'hFF;
    cs2_in = 8'hFF;

    // 1: reset held while PHI2 toggles.
    errs = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (err1 || err2) errs++;
    end
    chk("rst_rdy", {31'd0, rdy1}, 32'd1);
    chk("rst_cs", {24'd0, cs1_out}, 32'hFF);
    chk("rst_wait", {31'd0, wait1}, 32'd0);
    chk("rst_err", errs, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 2: zero-wait select CS1.
    cs1_in = 8'hFD;
    @(negedge clk);
    chk("zw_cs_lat1", {24'd0, cs1_out}, 32'hFD);
    lows = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (!rdy1) lows++;
    end
    chk("zw_rdy_low", lows, 0);

    // 3: two-wait select CS0, decoder moves to CS2 mid-WAIT.
    cs1_in = 8'hFE;
    wait_low(20, ok);
    chk("tw_fall", {31'd0, ok}, 32'd1);
    chk("tw_wait_act", {31'd0, wait1}, 32'd1);
    repeat (3) @(negedge clk);
    cs1_in = 8'hFB;
    repeat (2) @(negedge clk);
    chk("tw_cs_hold", {24'd0, cs1_out}, 32'hFE);
    count_low(6, n);
    chk("tw_low_clks", n, 16);
    @(negedge clk);
    chk("tw_cs_release", {24'd0, cs1_out}, 32'hFB);
    chk("tw_wait_off", {31'd0, wait1}, 32'd0);

    // 4: two selects active at a PHI2 rise.
    cs1_in = 8'hFC;
    errs = 0;
    lows = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (err1) errs++;
      if (!rdy1) lows++;
    end
    chk("ms_err_pulses", errs, 1);
    chk("ms_rdy_low", lows, 0);
    chk("ms_cs", {24'd0, cs1_out}, 32'hFC);

    // 5a: ena drop while in WAIT with cnt=2.
    cs1_in = 8'hFE;
    wait_low(20, ok);
    chk("ab_fall", {31'd0, ok}, 32'd1);
    repeat (2) @(negedge clk);
    ena = 1'b0;
    @(negedge clk);
    chk("ab_ena_rdy", {31'd0, rdy1}, 32'd1);
    chk("ab_ena_cs", {24'd0, cs1_out}, 32'hFF);
    chk("ab_ena_wait", {31'd0, wait1}, 32'd0);
    ena = 1'b1;

    // 5b: asynchronous reset while in WAIT, checked before any clock edge.
    wait_low(20, ok);
    chk("ab_fall2", {31'd0, ok}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ab_rst_rdy", {31'd0, rdy1}, 32'd1);
    chk("ab_rst_cs", {24'd0, cs1_out}, 32'hFF);
    chk("ab_rst_wait", {31'd0, wait1}, 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    cs1_in = 8'hFF;
    repeat (2) @(negedge clk);

    // 6: CS7 with 7 waits on the second instance, back-to-back cycles.
    use2   = 1'b1;
    cs2_in = 8'h7F;
    wait_low(20, ok);
    chk("c7_fall", {31'd0, ok}, 32'd1);
    repeat (3) @(negedge clk);
    chk("c7_cs_hold", {24'd0, cs2_out}, 32'h7F);
    chk("c7_wait_act", {31'd0, wait2}, 32'd1);
    count_low(4, n);
    chk("c7_low1", n, 56);
    count_high(1, n);
    chk("c7_gap", n, 8);
    count_low(1, n);
    chk("c7_low2", n, 56);
    chk("c7_no_err", {31'd0, err2}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
